uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter for the bridge's host-facing link. It sends bytes from the JTAG-side logic as 8N1 frames (configurable stop-bit count) on a serial line. Bytes enter through a valid/ready handshake into a small FIFO, so the upstream logic can post short bursts without waiting for each frame to finish. It pairs with the bridge's UART receiver, using the same clock and the same baud arithmetic.

Parameters:
CLK_FREQ, 10_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division, truncating); BAUD_DIV must be >= 2
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
tx_data  in  8  byte to send
tx_valid  in  1  upstream has a byte on tx_data
tx_ready  out  1  FIFO can accept a byte; equals !full
tx  out  1  serial output, registered, idles high
busy  out  1  high when the FIFO is non-empty or a frame is in progress
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued, excluding the frame being shifted

Behaviour:
- Reset (async) values:
  - tx=1, tx_ready=1, busy=0, fifo_level=0.
  - FSM=IDLE; FIFO pointers and all counters cleared.
  - Asserting reset mid-frame forces tx high immediately and discards the in-flight frame and all queued bytes.
- Push: a byte is written on a rising edge where tx_valid && tx_ready. tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - When full, tx_ready=0 and the byte is not written; no overflow is possible.
- Pop: on a rising edge where the FSM is IDLE (or finishing the last stop bit) and the FIFO is non-empty.
  - The head byte is loaded into the shift register and the FSM enters START.
- Simultaneous push and pop: both take effect and fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the extra MSB of the pointers.
- FSM states:
  - IDLE: tx=1. Leave on pop.
  - START: tx=0 for BAUD_DIV cycles, then enter DATA with bit index 0.
  - DATA: tx=shift[bit index] for BAUD_DIV cycles per bit, LSB first. After bit 7, enter STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV cycles. On the last cycle, pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
- Baud counter: loaded with BAUD_DIV-1 on entering each bit and decremented each cycle; the bit ends when it reaches 0. Width is $clog2(BAUD_DIV) bits.
- Latency: a byte pushed at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1. tx falls immediately after edge E+1.
- Frame length: exactly (9+STOP_BITS)*BAUD_DIV cycles.
- Back-to-back frames: no idle gap between the final stop bit and the next start bit.
- busy = (state != IDLE) || (fifo_level != 0). busy falls on the edge that returns the FSM to IDLE with an empty FIFO.
- tx is driven from a flop only, with no combinational path to the pin.

Test Plan:
- Reset, then idle 50 cycles -> tx=1, tx_ready=1, busy=0, fifo_level=0 throughout.
- CLK_FREQ=1000, BAUD_RATE=100 (BAUD_DIV=10); push 0x55 -> tx low 1 cycle after the push edge and lasts 10 cycles:
  - then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles;
  - frame = 100 cycles; busy falls at frame end.
- Same config, push 0xA3, 0x0F, 0xFF, 0x00 on consecutive cycles with FIFO_DEPTH=4:
  - all four are accepted; fifo_level peaks at 3;
  - the four frames are contiguous, 400 cycles total, with no extra idle cycle;
  - decoded bytes match in order.
- Hold tx_valid for 6 bytes with FIFO_DEPTH=4:
  - tx_ready drops after the FIFO fills and re-asserts for one push each time a pop occurs;
  - no byte is lost or duplicated; output order equals input order.
- STOP_BITS=2, push 0x81 -> stop period is 20 cycles high and the frame is 110 cycles.
- Assert rst mid-DATA of byte 0x3C with 2 bytes queued:
  - tx goes high asynchronously; fifo_level=0 and busy=0;
  - after release, no frame is emitted until a new push.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1/8N2 UART transmitter with a small valid/ready input FIFO.
//               Frames are start bit, 8 data bits LSB first, then STOP_BITS
//               stop bits, each bit lasting BAUD_DIV clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] C_BAUD_LOAD = BW'(BAUD_DIV - 1);
  localparam logic          C_LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  // Transmit datapath registers
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_stop;
  logic [7:0]    r_shift;
  logic          r_tx;

  // Next-state values
  state_t        w_state_nx;
  logic [BW-1:0] w_baud_nx;
  logic [2:0]    w_bit_nx;
  logic          w_stop_nx;
  logic [7:0]    w_shift_nx;
  logic          w_tx_nx;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_done;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push      = tx_valid && !w_full;
  assign w_baud_done = (r_baud == '0);

  assign tx_ready    = !w_full;
  assign fifo_level  = r_wr_ptr - r_rd_ptr;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign tx          = r_tx;

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  // FIFO pointer update on push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Next-state logic: frame sequencing, baud timing and the pop decision
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_bit_nx   = r_bit;
    w_stop_nx  = r_stop;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    w_tx_nx    = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_mem[r_rd_ptr[AW-1:0]];
          w_baud_nx  = C_BAUD_LOAD;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_nx = S_DATA;
          w_bit_nx   = 3'd0;
          w_baud_nx  = C_BAUD_LOAD;
        end else begin
          w_baud_nx  = r_baud - 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nx = C_BAUD_LOAD;
          if (r_bit == 3'd7) begin
            w_state_nx = S_STOP;
            w_stop_nx  = 1'b0;
          end else begin
            w_bit_nx   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          if (r_stop == C_LAST_STOP) begin
            // Chain straight into the next frame so there is no idle gap
            if (!w_empty) begin
              w_pop      = 1'b1;
              w_shift_nx = r_mem[r_rd_ptr[AW-1:0]];
              w_baud_nx  = C_BAUD_LOAD;
              w_state_nx = S_START;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_stop_nx = 1'b1;
            w_baud_nx = C_BAUD_LOAD;
          end
        end else begin
          w_baud_nx = r_baud - 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so tx is purely a flop
    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[w_bit_nx];
      default: w_tx_nx = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_stop  <= 1'b0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_stop  <= w_stop_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx (BAUD_DIV = 10),
//               one instance with 1 stop bit and one with 2 stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int BD = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [2:0] fifo_level;
  logic [7:0] tx_data2  = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2;
  logic [2:0] fifo_level2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_falls  = 0;

  logic [7:0] q0_byte[$];
  int         q0_start[$];
  bit         q0_bad[$];
  logic [7:0] q1_byte[$];
  int         q1_start[$];
  bit         q1_bad[$];

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  always #5 clk = ~clk;

  // Edge counter used to time frames
  always @(posedge clk) cyc <= cyc + 1;

  // Count falling edges on the line to detect spurious frames
  always @(negedge tx) n_falls++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  // Decode frames cycle by cycle: each bit must hold for exactly BD cycles
  task automatic decode_loop(input bit sel, input int nstop);
    int n;
    int st;
    logic v;
    logic [7:0] d;
    bit bad;
    n = (9 + nstop) * BD;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && line(sel) === 1'b0) begin
        st  = cyc;
        bad = 1'b0;
        d   = 8'h00;
        for (int i = 0; i < n; i++) begin
          v = line(sel);
          if (i < BD) begin
            if (v !== 1'b0) bad = 1'b1;
          end else if (i < 9 * BD) begin
            int k;
            k = i / BD - 1;
            if (i % BD == 0) d[k] = v;
            else if (v !== d[k]) bad = 1'b1;
          end else begin
            if (v !== 1'b1) bad = 1'b1;
          end
          if (i < n - 1) @(negedge clk);
        end
        if (sel) begin
          q1_byte.push_back(d); q1_start.push_back(st); q1_bad.push_back(bad);
        end else begin
          q0_byte.push_back(d); q0_start.push_back(st); q0_bad.push_back(bad);
        end
      end
    end
  endtask

  initial decode_loop(1'b0, 1);
  initial decode_loop(1'b1, 2);

  task automatic wait_idle(input bit sel, input string tag, output int fall_cyc);
    int k;
    k = 0;
    while ((sel ? busy2 : busy) !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) check({tag, "_timeout_busy"}, sel ? busy2 : busy, 0);
    fall_cyc = cyc;
  endtask

  task automatic clear_q0();
    q0_byte.delete(); q0_start.delete(); q0_bad.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] burst[4];
    logic [7:0] hold[6];
    int pc, fc, peak, lvl, idx, low_cnt, first_low_lvl, guard, nf;
    bit acc;

    burst = '{8'hA3, 8'h0F, 8'hFF, 8'h00};
    hold  = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'h7E, 8'hE7};

    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_ready", tx_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_level", fifo_level, 0);
      check("idle_tx2", tx2, 1);
    end

    // Single byte 0x55: latency, bit timing, frame length, busy fall
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    pc = cyc;
    check("lat_level_after_push", fifo_level, 1);
    check("lat_tx_after_push", tx, 1);
    @(negedge clk);
    check("lat_tx_start", tx, 0);
    check("lat_busy", busy, 1);
    check("lat_level_after_pop", fifo_level, 0);
    wait_idle(1'b0, "b55", fc);
    check("b55_count", q0_byte.size(), 1);
    if (q0_byte.size() >= 1) begin
      check("b55_byte", q0_byte[0], 8'h55);
      check("b55_shape", q0_bad[0], 0);
      check("b55_latency", q0_start[0] - pc, 1);
      check("b55_busy_fall", fc - q0_start[0], 100);
    end
    clear_q0();

    // Burst of four on consecutive cycles
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      check("burst_ready", tx_ready, 1);
      tx_data = burst[i]; tx_valid = 1'b1;
      @(negedge clk);
      lvl = int'(fifo_level);
      if (i == 0) pc = cyc;
      if (i == 1) check("pushpop_level", fifo_level, 1);
      if (lvl > peak) peak = lvl;
    end
    tx_valid = 1'b0;
    check("burst_peak", peak, 3);
    wait_idle(1'b0, "burst", fc);
    check("burst_count", q0_byte.size(), 4);
    if (q0_byte.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("burst_byte", q0_byte[i], burst[i]);
        check("burst_shape", q0_bad[i], 0);
        if (i > 0) check("burst_gap", q0_start[i] - q0_start[i-1], 100);
      end
      check("burst_latency", q0_start[0] - pc, 1);
      check("burst_total", fc - q0_start[0], 400);
    end
    clear_q0();

    // Hold tx_valid for six bytes: backpressure
    idx = 0; low_cnt = 0; first_low_lvl = -1; guard = 0;
    tx_data = hold[0]; tx_valid = 1'b1;
    while (idx < 6 && guard < 1000) begin
      acc = tx_ready;
      if (!tx_ready) begin
        low_cnt++;
        if (first_low_lvl < 0) first_low_lvl = int'(fifo_level);
      end
      @(negedge clk);
      guard++;
      if (acc) begin
        idx++;
        if (idx < 6) tx_data = hold[idx];
        else tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    check("hold_accepted", idx, 6);
    check("hold_ready_low_cycles", low_cnt, 97);
    check("hold_full_level", first_low_lvl, 4);
    wait_idle(1'b0, "hold", fc);
    check("hold_count", q0_byte.size(), 6);
    if (q0_byte.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("hold_byte", q0_byte[i], hold[i]);
        check("hold_shape", q0_bad[i], 0);
        if (i > 0) check("hold_gap", q0_start[i] - q0_start[i-1], 100);
      end
    end
    clear_q0();

    // Two stop bits: 0x81, 110-cycle frame
    tx_data2 = 8'h81; tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    pc = cyc;
    wait_idle(1'b1, "stop2", fc);
    check("stop2_count", q1_byte.size(), 1);
    if (q1_byte.size() >= 1) begin
      check("stop2_byte", q1_byte[0], 8'h81);
      check("stop2_shape", q1_bad[0], 0);
      check("stop2_latency", q1_start[0] - pc, 1);
      check("stop2_frame_len", fc - q1_start[0], 110);
    end

    // Reset mid-DATA of 0x3C with two bytes queued
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_level", fifo_level, 2);
    check("pre_rst_tx", tx, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx", tx, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    nf = n_falls;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (i % 50 == 49) check("post_rst_busy", busy, 0);
    end
    check("post_rst_no_frame", n_falls - nf, 0);
    clear_q0();
    tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(1'b0, "post_rst", fc);
    check("post_rst_count", q0_byte.size(), 1);
    if (q0_byte.size() >= 1) begin
      check("post_rst_byte", q0_byte[0], 8'h5A);
      check("post_rst_shape", q0_bad[0], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
